// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pipeline: default geometry, controller
// state encodings and the 3x3 window index/packing helpers.
package sobel_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;

    // Controller states: S0 reset, S1/S2 running (Enable high), S3 finish.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } sobel_state_e;

    // Linear index of window tap p[r][c]; r0 = top row, c0 = left column.
    function automatic int win_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

    // Bit offset of tap p[r][c] in the flat window bus.
    function automatic int win_lsb(input int r, input int c, input int pw);
        return win_idx(r, c) * pw;
    endfunction

    localparam int P00 = win_idx(0, 0);
    localparam int P01 = win_idx(0, 1);
    localparam int P02 = win_idx(0, 2);
    localparam int P10 = win_idx(1, 0);
    localparam int P11 = win_idx(1, 1);
    localparam int P12 = win_idx(1, 2);
    localparam int P20 = win_idx(2, 0);
    localparam int P21 = win_idx(2, 1);
    localparam int P22 = win_idx(2, 2);

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage. Combinational read, registered write, so a
// read and write to the same address in one cycle returns the old contents.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int WIDTH = PIX_W_DEF,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic [AW-1:0]    addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Write the shifted-down pixel at the current column; no reset, stale
    // contents are masked downstream until two full lines have passed.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-order pixel fetch and 3x3 window generator. Issues read addresses,
// captures returning pixels one cycle later, keeps two previous lines in line
// buffers and emits one window per captured pixel once x>=2 and y>=2.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = 16
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Enable,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [PIX_W-1:0]    pix_in,
    output logic [9*PIX_W-1:0]  win,
    output logic                win_valid,
    output logic [ADDR_W/2-1:0] out_row,
    output logic [ADDR_W/2-1:0] out_col,
    output logic                isEnd
);

    localparam int                CW        = ADDR_W / 2;
    localparam int                LB_AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CW-1:0]     X_MAX     = CW'(IMG_W - 1);
    localparam logic [CW-1:0]     Y_MAX     = CW'(IMG_H - 1);
    localparam logic [CW-1:0]     C_ONE     = CW'(1);
    localparam logic [CW-1:0]     C_TWO     = CW'(2);

    logic                    fetch_done;
    logic                    issue;
    logic                    rd_vld_d;
    logic                    capture;
    logic [CW-1:0]           x;
    logic [CW-1:0]           y;
    logic [8:0][PIX_W-1:0]   win_r;
    logic [PIX_W-1:0]        lb0_q;
    logic [PIX_W-1:0]        lb1_q;

    assign issue   = Enable & ~fetch_done;
    assign capture = rd_vld_d;

    // Address generator: one read per enabled cycle until the last pixel.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            rd_addr    <= '0;
            fetch_done <= 1'b0;
            rd_vld_d   <= 1'b0;
        end else begin
            rd_vld_d <= issue;
            if (issue) begin
                if (rd_addr == LAST_ADDR) begin
                    fetch_done <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

    // lb0 holds row y-2, lb1 holds row y-1 at each column; both rotate on capture.
    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (LB_AW)
    ) lb0 (
        .CLK   (CLK),
        .addr  (x[LB_AW-1:0]),
        .we    (capture),
        .wdata (lb1_q),
        .rdata (lb0_q)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (LB_AW)
    ) lb1 (
        .CLK   (CLK),
        .addr  (x[LB_AW-1:0]),
        .we    (capture),
        .wdata (pix_in),
        .rdata (lb1_q)
    );

    // Capture: shift window left, append new column, step raster position and
    // flag windows whose three columns all lie in the current row.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            x         <= '0;
            y         <= '0;
            win_r     <= '0;
            win_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            isEnd     <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (capture) begin
                win_r[P00] <= win_r[P01];
                win_r[P01] <= win_r[P02];
                win_r[P02] <= lb0_q;
                win_r[P10] <= win_r[P11];
                win_r[P11] <= win_r[P12];
                win_r[P12] <= lb1_q;
                win_r[P20] <= win_r[P21];
                win_r[P21] <= win_r[P22];
                win_r[P22] <= pix_in;

                win_valid <= (x >= C_TWO) && (y >= C_TWO);
                out_col   <= x - C_ONE;
                out_row   <= y - C_ONE;

                if ((x == X_MAX) && (y == Y_MAX)) begin
                    isEnd <= 1'b1;
                end

                if (x == X_MAX) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // Flatten the window: tap p[r][c] lands at bits (3r+c)*PIX_W.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign win[win_lsb(r, c, PIX_W) +: PIX_W] = win_r[win_idx(r, c)];
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench: 5x4 frame (pix = addr) with table of expected windows, an
// Enable gap, a mid-frame reset, post-isEnd hold, and a 3x3 frame.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int AW = 16;
    localparam int CW = AW / 2;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          Enable = 1'b0;
    logic          Enable3 = 1'b0;
    logic [AW-1:0] rd_addr, rd_addr3;
    logic [PW-1:0] pix_in, pix_in3;
    logic [9*PW-1:0] win, win3;
    logic          win_valid, win_valid3;
    logic [CW-1:0] out_row, out_col, out_row3, out_col3;
    logic          isEnd, isEnd3;

    always #5 CLK = ~CLK;

    // Image memory models: one-cycle read latency, pixel value = address.
    always @(posedge CLK) begin
        pix_in  <= rd_addr[PW-1:0];
        pix_in3 <= rd_addr3[PW-1:0];
    end

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW)) dut (
        .CLK(CLK), .Reset(Reset), .Enable(Enable), .rd_addr(rd_addr),
        .pix_in(pix_in), .win(win), .win_valid(win_valid),
        .out_row(out_row), .out_col(out_col), .isEnd(isEnd)
    );

    sobel_window_gen #(.IMG_W(3), .IMG_H(3), .PIX_W(PW), .ADDR_W(AW)) dut3 (
        .CLK(CLK), .Reset(Reset), .Enable(Enable3), .rd_addr(rd_addr3),
        .pix_in(pix_in3), .win(win3), .win_valid(win_valid3),
        .out_row(out_row3), .out_col(out_col3), .isEnd(isEnd3)
    );

    typedef struct {
        int              cyc;
        logic [CW-1:0]   row;
        logic [CW-1:0]   col;
        logic [9*PW-1:0] w;
    } vec_t;

    vec_t tbl [6];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [9*PW-1:0] pk(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
        return {PW'(a8), PW'(a7), PW'(a6), PW'(a5), PW'(a4), PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hold reset, then release mid-cycle so the current cycle is cycle 0.
    task automatic do_reset();
        Reset   = 1'b1;
        Enable  = 1'b0;
        Enable3 = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    // Full 5x4 frame; Enable low for cycles [off_start, off_start+off_len).
    task automatic run_frame(input int off_start, input int off_len, input int shift, input int ncyc);
        int  idx;
        bit  exp_v;
        bit  gap;
        idx = 0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            gap   = (c >= off_start) && (c < off_start + off_len);
            exp_v = (idx < 6) && (tbl[idx].cyc + shift == c);
            if (c == 0) begin
                check("reset rd_addr", rd_addr, 0);
                check("reset win", win, 0);
                check("reset out_row", out_row, 0);
                check("reset out_col", out_col, 0);
            end
            check("win_valid", win_valid, exp_v);
            check("isEnd", isEnd, (c >= 21 + shift));
            if (exp_v) begin
                check("win", win, tbl[idx].w);
                check("out_row", out_row, tbl[idx].row);
                check("out_col", out_col, tbl[idx].col);
                idx++;
            end
            if (gap) check("rd_addr frozen", rd_addr, off_start);
            if (c >= 19 + shift) check("rd_addr hold at end", rd_addr, W * H - 1);
            Enable = !gap;
            @(negedge CLK);
        end
        check("window count", idx, 6);
    endtask

    initial begin
        tbl[0] = '{14, 1, 1, pk(0, 1, 2, 5, 6, 7, 10, 11, 12)};
        tbl[1] = '{15, 1, 2, pk(1, 2, 3, 6, 7, 8, 11, 12, 13)};
        tbl[2] = '{16, 1, 3, pk(2, 3, 4, 7, 8, 9, 12, 13, 14)};
        tbl[3] = '{19, 2, 1, pk(5, 6, 7, 10, 11, 12, 15, 16, 17)};
        tbl[4] = '{20, 2, 2, pk(6, 7, 8, 11, 12, 13, 16, 17, 18)};
        tbl[5] = '{21, 2, 3, pk(7, 8, 9, 12, 13, 14, 17, 18, 19)};

        // Continuous Enable; held high well past isEnd (no refetch, no windows).
        run_frame(-1, 0, 0, 32);

        // Finish -> Reset: the sticky flag drops one cycle after Reset.
        Reset = 1'b1;
        @(negedge CLK);
        check("isEnd cleared by reset", isEnd, 0);

        // Enable gap of 3 cycles in row 2.
        run_frame(11, 3, 3, 32);

        // Reset mid-frame at cycle 10.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            Enable = 1'b1;
            @(negedge CLK);
        end
        check("pre-reset win nonzero", (win != '0), 1);
        check("pre-reset out_col", out_col, 2);
        Reset = 1'b1;
        @(negedge CLK);
        check("mid reset rd_addr", rd_addr, 0);
        check("mid reset win", win, 0);
        check("mid reset win_valid", win_valid, 0);
        check("mid reset out_col", out_col, 0);
        check("mid reset out_row", out_row, 0);
        check("mid reset isEnd", isEnd, 0);

        // Restart reproduces the first frame.
        run_frame(-1, 0, 0, 26);

        // 3x3 frame: exactly one window, isEnd in the same cycle.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            check("3x3 win_valid", win_valid3, (c == 10));
            check("3x3 isEnd", isEnd3, (c >= 10));
            if (c == 10) begin
                check("3x3 win", win3, pk(0, 1, 2, 3, 4, 5, 6, 7, 8));
                check("3x3 out_row", out_row3, 1);
                check("3x3 out_col", out_col3, 1);
            end
            Enable3 = 1'b1;
            @(negedge CLK);
        end
        check("3x3 rd_addr hold", rd_addr3, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
